// File: rtl/mod7_check_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod7_pkg
// Brief    : Shared types and mod-7 arithmetic helpers for the serial link.
// Revision : 1.0  initial release
// ============================================================================
package mod7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int CHECK_BITS = 3;

    // (2r + b) mod 7 as a 7-entry table of 2r mod 7, with the single wrap case 6+1.
    function automatic logic [2:0] mod7_step(input logic [2:0] r, input logic b);
        logic [2:0] dbl;
        case (r)
            3'd0:    dbl = 3'd0;
            3'd1:    dbl = 3'd2;
            3'd2:    dbl = 3'd4;
            3'd3:    dbl = 3'd6;
            3'd4:    dbl = 3'd1;
            3'd5:    dbl = 3'd3;
            3'd6:    dbl = 3'd5;
            default: dbl = 3'd0;
        endcase
        return (dbl == 3'd6 && b) ? 3'd0 : dbl + {2'b00, b};
    endfunction

    function automatic logic [2:0] mod7_check(input logic [2:0] r);
        return (r == 3'd0) ? 3'd0 : 3'd7 - r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod7_check_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : mod7_check_serializer_if
// Brief    : Load handshake and serial output bundle of the mod-7 serializer.
// Revision : 1.0  initial release
// ============================================================================
interface mod7_check_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Data_In;
    logic             Load_Valid;
    logic             Load_Ready;
    logic             Serial_Out;
    logic             Bit_Valid;
    logic             Check_Phase;
    logic             Frame_End;

    modport master (
        output Data_In, Load_Valid,
        input  Load_Ready, Serial_Out, Bit_Valid, Check_Phase, Frame_End
    );

    modport slave (
        input  Data_In, Load_Valid,
        output Load_Ready, Serial_Out, Bit_Valid, Check_Phase, Frame_End
    );
endinterface
`default_nettype wire

// File: rtl/mod7_check_serializer_step_unit.sv
`default_nettype none
// ============================================================================
// Module   : mod7_step_unit
// Brief    : Combinational 3-bit remainder update r' = (2r + b) mod 7.
// Revision : 1.0  initial release
// ============================================================================
module mod7_step_unit
    import mod7_pkg::*;
(
    input  wire logic [2:0] i_rem,
    input  wire logic       i_bit,
    output logic      [2:0] o_rem
);
    assign o_rem = mod7_step(i_rem, i_bit);
endmodule
`default_nettype wire

// File: rtl/mod7_check_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mod7_check_serializer
// Brief    : Shifts a word out MSB-first followed by a 3-bit code that makes
//            the whole frame divisible by 7. Optional Abort port: MOD7_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mod7_check_serializer
    import mod7_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic Clock,
    input  wire logic Reset,
`ifdef MOD7_ABORT_EN
    input  wire logic Abort,
`endif
    mod7_check_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t                  r_state, w_state_next;
    logic [WIDTH-1:0]        r_shreg, w_shreg_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic [2:0]              r_rem, w_rem_next, w_rem_step, w_code;
    logic [CHECK_BITS-1:0]   r_code, w_code_next;
    logic [1:0]              r_chk_cnt, w_chk_cnt_next;
    logic                    r_serial, w_serial_next;
    logic                    r_bit_valid, w_bit_valid_next;
    logic                    r_check_phase, w_check_phase_next;
    logic                    r_frame_end, w_frame_end_next;

    mod7_step_unit u_step (
        .i_rem (r_rem),
        .i_bit (r_shreg[WIDTH-1]),
        .o_rem (w_rem_step)
    );

    // Code is taken from the remainder that includes the bit leaving this cycle.
    assign w_code = mod7_check(w_rem_step);

    always_comb begin
        w_state_next       = r_state;
        w_shreg_next       = r_shreg;
        w_cnt_next         = r_cnt;
        w_rem_next         = r_rem;
        w_code_next        = r_code;
        w_chk_cnt_next     = r_chk_cnt;
        w_serial_next      = 1'b0;
        w_bit_valid_next   = 1'b0;
        w_check_phase_next = 1'b0;
        w_frame_end_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.Load_Valid) begin
                    w_state_next     = DATA;
                    w_shreg_next     = bus.Data_In;
                    w_rem_next       = 3'd0;
                    w_cnt_next       = CNT_W'(WIDTH - 1);
                    w_serial_next    = bus.Data_In[WIDTH-1];
                    w_bit_valid_next = 1'b1;
                end
            end
            DATA: begin
                w_rem_next       = w_rem_step;
                w_shreg_next     = {r_shreg[WIDTH-2:0], 1'b0};
                w_bit_valid_next = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next       = CHECK;
                    w_serial_next      = w_code[2];
                    w_code_next        = {w_code[1:0], 1'b0};
                    w_chk_cnt_next     = 2'(CHECK_BITS - 1);
                    w_check_phase_next = 1'b1;
                end else begin
                    w_cnt_next    = r_cnt - 1'b1;
                    w_serial_next = r_shreg[WIDTH-2];
                end
            end
            CHECK: begin
                if (r_chk_cnt == 2'd0) begin
                    w_state_next = IDLE;
                end else begin
                    w_serial_next      = r_code[2];
                    w_code_next        = {r_code[1:0], 1'b0};
                    w_chk_cnt_next     = r_chk_cnt - 2'd1;
                    w_bit_valid_next   = 1'b1;
                    w_check_phase_next = 1'b1;
                    w_frame_end_next   = (r_chk_cnt == 2'd1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

`ifdef MOD7_ABORT_EN
        if (Abort && r_state != IDLE) begin
            w_state_next       = IDLE;
            w_serial_next      = 1'b0;
            w_bit_valid_next   = 1'b0;
            w_check_phase_next = 1'b0;
            w_frame_end_next   = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_cnt         <= '0;
            r_rem         <= 3'd0;
            r_code        <= '0;
            r_chk_cnt     <= 2'd0;
            r_serial      <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_check_phase <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shreg       <= w_shreg_next;
            r_cnt         <= w_cnt_next;
            r_rem         <= w_rem_next;
            r_code        <= w_code_next;
            r_chk_cnt     <= w_chk_cnt_next;
            r_serial      <= w_serial_next;
            r_bit_valid   <= w_bit_valid_next;
            r_check_phase <= w_check_phase_next;
            r_frame_end   <= w_frame_end_next;
        end
    end

    assign bus.Load_Ready  = (r_state == IDLE);
    assign bus.Serial_Out  = r_serial;
    assign bus.Bit_Valid   = r_bit_valid;
    assign bus.Check_Phase = r_check_phase;
    assign bus.Frame_End   = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_mod7_check_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod7_check_serializer
// Brief    : Randomized scoreboard bench for mod7_check_serializer.
// Revision : 1.0  initial release
// ============================================================================
module tb_mod7_check_serializer;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic b;
        logic cp;
        logic fe;
    } exp_t;

    logic Clock;
    logic Reset;
`ifdef MOD7_ABORT_EN
    logic Abort;
`endif

    mod7_check_serializer_if #(.WIDTH(WIDTH)) bus ();

    mod7_check_serializer #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
`ifdef MOD7_ABORT_EN
        .Abort (Abort),
`endif
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    exp_t             q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               last_acc = 0;
    bit               have_last = 0;
    bit               lv_run = 0;
    bit               pending = 0;
    logic [WIDTH-1:0] pending_word;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Frame = word * 8 + c, with c chosen so that the frame is a multiple of 7.
    task automatic push_frame(input logic [WIDTH-1:0] w);
        int               c;
        logic [WIDTH+2:0] f;
        exp_t             e;
        c = (7 - (int'(w) % 7)) % 7;
        f = {w, 3'(c)};
        for (int i = WIDTH + 2; i >= 0; i--) begin
            e.b  = f[i];
            e.cp = (i < 3);
            e.fe = (i == 0);
            q.push_back(e);
        end
    endtask

    task automatic drive(input logic lv, input logic [WIDTH-1:0] d, output logic acc);
        @(posedge Clock);
        #1;
        cyc++;
        if (Reset) begin
            q.delete();
            have_last = 0;
        end else if (pending) begin
            push_frame(pending_word);
        end
        pending = 0;
        bus.Load_Valid = lv;
        bus.Data_In    = d;
        acc = lv && bus.Load_Ready && !Reset;
        if (!lv) lv_run = 0;
        if (acc) begin
            if (lv_run && have_last) check("accept_gap", cyc - last_acc, WIDTH + 4);
            last_acc     = cyc;
            have_last    = 1;
            lv_run       = 1;
            pending      = 1;
            pending_word = d;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        logic acc;
        acc = 0;
        for (int t = 0; t < 2 * (WIDTH + 4) + 2; t++) begin
            drive(1'b1, w, acc);
            if (acc) break;
        end
        if (!acc) check("load_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int t = 0; t < n; t++) drive(1'b0, WIDTH'($urandom), acc);
    endtask

    task automatic drain();
        logic acc;
        bit   done;
        done = 0;
        for (int t = 0; t < 4 * (WIDTH + 4) && !done; t++) begin
            drive(1'b0, WIDTH'($urandom), acc);
            done = (q.size() == 0) && !pending && bus.Load_Ready;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        int   chk_r;
        int   cp_cnt;
        chk_r  = 0;
        cp_cnt = 0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                check("load_ready", int'(bus.Load_Ready), int'(q.size() == 0));
                check("bit_valid", int'(bus.Bit_Valid), int'(q.size() != 0));
                if (bus.Bit_Valid && q.size() != 0) begin
                    e = q.pop_front();
                    check("frame_bit", int'({bus.Serial_Out, bus.Check_Phase, bus.Frame_End}),
                          int'({e.b, e.cp, e.fe}));
                    chk_r = (2 * chk_r + int'(bus.Serial_Out)) % 7;
                    if (bus.Check_Phase) cp_cnt++;
                    if (bus.Frame_End) begin
                        check("frame_rem", chk_r, 0);
                        check("check_cycles", cp_cnt, 3);
                        chk_r  = 0;
                        cp_cnt = 0;
                    end
                end else if (!bus.Bit_Valid) begin
                    chk_r  = 0;
                    cp_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic acc;
        Reset          = 1'b1;
        bus.Load_Valid = 1'b0;
        bus.Data_In    = '0;
`ifdef MOD7_ABORT_EN
        Abort          = 1'b0;
`endif
        idle(3);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_state",
              int'({bus.Load_Ready, bus.Bit_Valid, bus.Serial_Out, bus.Check_Phase, bus.Frame_End}),
              int'(5'b10000));

        // Directed words, then Load_Valid held high across several frames.
        send(8'h07); drain();
        send(8'hFF); drain();
        for (int k = 0; k < 3; k++) send(8'h01);
        drain();

        // Reset for two cycles while data bits are in flight.
        send(8'hA5);
        idle(3);
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
        @(negedge Clock);
        check("mid_reset_idle", int'({bus.Load_Ready, bus.Bit_Valid}), int'(2'b10));
        send(8'h3C); drain();

        // Exhaustive back-to-back sweep with Load_Valid continuously high.
        for (int w = 0; w < (1 << WIDTH); w++) send(WIDTH'(w));
        drain();

        // Random offers and data churn, including while busy.
        for (int t = 0; t < 400; t++) drive($urandom_range(0, 3) != 0, WIDTH'($urandom), acc);
        drain();

`ifdef MOD7_ABORT_EN
        // Abort while the 4th data bit is on the line.
        send(8'hB6);
        idle(4);
        Abort = 1'b1;
        idle(1);
        Abort = 1'b0;
        q.delete();
        @(negedge Clock);
        check("abort_idle", int'({bus.Load_Ready, bus.Bit_Valid, bus.Frame_End}), int'(3'b100));
        drain();

        // Abort in IDLE does not block a load.
        Abort = 1'b1;
        send(8'h5A);
        idle(1);
        Abort = 1'b0;
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
